dma_bus_arbiter: RTL and testbench

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

---
 rtl/dma_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: four-channel DMA bus arbiter.
// Requests the bus from the CPU (hold/hlda) and hands it to one DMA channel
// at a time. A grant lasts at most BURST words. It also ends on terminal
// count, on the channel dropping its request, or on the CPU reclaiming the bus.
// Build option: define DMA_ARB_FIXED_PRIO_EN for fixed priority (channel 0
// highest). When it is left undefined, selection is round-robin.
module dma_bus_arbiter #(
  parameter int unsigned BURST = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] dreq,
  input  logic       hlda,
  input  logic       xfer_done,
  input  logic       eop,
  output logic       hold,
  output logic [3:0] dack,
  output logic [1:0] cur_ch,
  output logic       busy
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD_REQ = 3'd1,
    GRANT    = 3'd2,
    ARB      = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              hold_nxt;
  logic              busy_nxt;
  logic [NCH-1:0]    dack_nxt;
  logic [CH_W-1:0]   cur_ch_nxt;
  logic [CH_W-1:0]   winner;
  logic              req_any;
  logic              grant_end;
  logic              grant_now;

  assign req_any   = |dreq;
  // A burst stops on terminal count, on the last allowed beat, or when the
  // owning channel withdraws its request; all three end the grant once.
  assign grant_end = eop | (xfer_done & (cnt == LAST_BEAT)) | ~dreq[cur_ch];

`ifdef DMA_ARB_FIXED_PRIO_EN

  // Fixed priority winner: lowest requesting channel index.
  always_comb begin
    winner = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (dreq[i]) winner = CH_W'(i);
    end
  end

`else

  logic [CH_W-1:0] last_winner;
  logic [CH_W-1:0] last_winner_nxt;
  logic [CH_W-1:0] cand;
  logic            found;

  // Round-robin winner: first requester after the previous winner, wrapping.
  always_comb begin
    winner = last_winner;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = last_winner + CH_W'(i);
      if (!found && dreq[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Remember who was served last so the search rotates.
  always_comb begin
    last_winner_nxt = last_winner;
    if (grant_now) last_winner_nxt = winner;
  end

  // Round-robin pointer register; reset points at channel 3 so channel 0 wins first.
  always_ff @(posedge clock) begin
    if (!reset_n) last_winner <= CH_W'(NCH - 1);
    else          last_winner <= last_winner_nxt;
  end

`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; losing hlda mid-burst takes precedence over burst end.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_any) state_nxt = HOLD_REQ;
      end
      HOLD_REQ: begin
        if (hlda) state_nxt = req_any ? GRANT : ARB;
      end
      GRANT: begin
        if (!hlda)          state_nxt = req_any ? HOLD_REQ : RELEASE;
        else if (grant_end) state_nxt = ARB;
      end
      ARB: begin
        state_nxt = (hlda && req_any) ? GRANT : RELEASE;
      end
      RELEASE: begin
        if (!hlda) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/next-value logic for the registered outputs and beat counter.
  always_comb begin
    grant_now  = (state_nxt == GRANT) && (state != GRANT);
    hold_nxt   = !((state_nxt == IDLE) || (state_nxt == RELEASE));
    busy_nxt   = (state_nxt == GRANT);
    dack_nxt   = '0;
    cur_ch_nxt = cur_ch;
    cnt_nxt    = cnt;
    if (grant_now) begin
      dack_nxt   = NCH'(1) << winner;
      cur_ch_nxt = winner;
      cnt_nxt    = '0;
    end else if (state_nxt == GRANT) begin
      dack_nxt = dack;
      if (xfer_done) cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Registered outputs and beat counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold   <= 1'b0;
      dack   <= '0;
      busy   <= 1'b0;
      cur_ch <= '0;
      cnt    <= '0;
    end else begin
      hold   <= hold_nxt;
      dack   <= dack_nxt;
      busy   <= busy_nxt;
      cur_ch <= cur_ch_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_dma_bus_arbiter;

  localparam int unsigned BURST_TB = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] dreq;
  logic       hlda;
  logic       xfer_done;
  logic       eop;
  logic       hold;
  logic [3:0] dack;
  logic [1:0] cur_ch;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  dma_bus_arbiter #(.BURST(BURST_TB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .dreq      (dreq),
    .hlda      (hlda),
    .xfer_done (xfer_done),
    .eop       (eop),
    .hold      (hold),
    .dack      (dack),
    .cur_ch    (cur_ch),
    .busy      (busy)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] dreq;
    logic       hlda;
    logic       xfer;
    logic       eop;
    logic       e_hold;
    logic [3:0] e_dack;
    logic       e_busy;
    logic [1:0] e_ch;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic r, input logic [3:0] d, input logic h,
                              input logic x, input logic e, input logic eh,
                              input logic [3:0] ed, input logic eb, input logic [1:0] ec);
    vec_t v;
    v.rst_n = r; v.dreq = d; v.hlda = h; v.xfer = x; v.eop = e;
    v.e_hold = eh; v.e_dack = ed; v.e_busy = eb; v.e_ch = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] d, input logic h,
                       input logic x, input logic e);
    reset_n = r; dreq = d; hlda = h; xfer_done = x; eop = e;
  endtask

  // Advance one clock and sample well after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  localparam int P_QUIET = 0, P_ASKING = 1, P_SERVING = 2, P_BETWEEN = 3, P_GIVING_BACK = 4;
  int   m_phase;
  int   m_ch;
  int   m_last;
  int   m_beats;
  logic m_hold;
  logic m_granted;

  function automatic int pick(input logic [3:0] req, input int last);
`ifdef DMA_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (req[k]) return k;
`else
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
`endif
    return 0;
  endfunction

  task automatic m_grant(input logic [3:0] req);
    m_ch      = pick(req, m_last);
    m_last    = m_ch;
    m_beats   = 0;
    m_granted = 1'b1;
    m_phase   = P_SERVING;
  endtask

  task automatic model_step(input logic r, input logic [3:0] d, input logic h,
                            input logic x, input logic e);
    if (!r) begin
      m_phase = P_QUIET; m_hold = 1'b0; m_granted = 1'b0;
      m_ch = 0; m_beats = 0; m_last = 3;
      return;
    end
    case (m_phase)
      P_QUIET: if (d != 0) begin m_phase = P_ASKING; m_hold = 1'b1; end
      P_ASKING: if (h) begin
        if (d != 0) m_grant(d);
        else        m_phase = P_BETWEEN;
      end
      P_SERVING: begin
        if (!h) begin
          m_granted = 1'b0;
          if (d != 0) begin m_phase = P_ASKING; m_hold = 1'b1; end
          else begin m_phase = P_GIVING_BACK; m_hold = 1'b0; end
        end else if (e || (x && (m_beats + 1 == int'(BURST_TB))) || !d[m_ch]) begin
          m_granted = 1'b0;
          m_phase   = P_BETWEEN;
        end else if (x) begin
          m_beats++;
        end
      end
      P_BETWEEN: begin
        if (h && d != 0) m_grant(d);
        else begin m_phase = P_GIVING_BACK; m_hold = 1'b0; end
      end
      default: if (!h) m_phase = P_QUIET;
    endcase
  endtask

  task automatic compare_model(input int cyc);
    logic [3:0] exp_dack;
    exp_dack = m_granted ? (4'b0001 << m_ch) : 4'b0000;
    check($sformatf("rnd%0d_hold", cyc), 32'(hold), 32'(m_hold));
    check($sformatf("rnd%0d_dack", cyc), 32'(dack), 32'(exp_dack));
    check($sformatf("rnd%0d_busy", cyc), 32'(busy), 32'(m_granted));
    if (m_granted) check($sformatf("rnd%0d_cur_ch", cyc), 32'(cur_ch), 32'(m_ch));
    check($sformatf("rnd%0d_onehot", cyc), 32'($onehot0(dack)), 32'd1);
  endtask

  initial begin
    int         beats;
    int         guard;
    int         ngr;
    logic [1:0] order[5];
    int         exp_order[5];
    logic [3:0] rd;
    logic       rh;
    logic       rr;

    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // ---------------- vector table ----------------
    vecs[0]  = mk(0, 4'b0000, 0, 0, 0,  0, 4'b0000, 0, 2'd0);
    vecs[1]  = mk(1, 4'b0001, 0, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[2]  = mk(1, 4'b0001, 0, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[3]  = mk(1, 4'b0001, 0, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[4]  = mk(1, 4'b0001, 1, 0, 0,  1, 4'b0001, 1, 2'd0);
    vecs[5]  = mk(1, 4'b0001, 1, 1, 0,  1, 4'b0001, 1, 2'd0);
    vecs[6]  = mk(1, 4'b0011, 1, 0, 1,  1, 4'b0000, 0, 2'd0);
    vecs[7]  = mk(1, 4'b0010, 1, 0, 0,  1, 4'b0010, 1, 2'd1);
    vecs[8]  = mk(1, 4'b0001, 1, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[9]  = mk(1, 4'b0000, 1, 0, 0,  0, 4'b0000, 0, 2'd0);
    vecs[10] = mk(1, 4'b0100, 1, 0, 0,  0, 4'b0000, 0, 2'd0);
    vecs[11] = mk(1, 4'b0100, 0, 0, 0,  0, 4'b0000, 0, 2'd0);
    vecs[12] = mk(1, 4'b0100, 0, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[13] = mk(1, 4'b0100, 1, 0, 0,  1, 4'b0100, 1, 2'd2);
    vecs[14] = mk(1, 4'b0100, 0, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[15] = mk(1, 4'b0000, 0, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[16] = mk(1, 4'b0000, 1, 0, 0,  1, 4'b0000, 0, 2'd0);
    vecs[17] = mk(1, 4'b1000, 1, 0, 0,  1, 4'b1000, 1, 2'd3);
    vecs[18] = mk(0, 4'b1000, 1, 0, 0,  0, 4'b0000, 0, 2'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst_n, vecs[i].dreq, vecs[i].hlda, vecs[i].xfer, vecs[i].eop);
      tick();
      check($sformatf("vec%0d_hold", i), 32'(hold), 32'(vecs[i].e_hold));
      check($sformatf("vec%0d_dack", i), 32'(dack), 32'(vecs[i].e_dack));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_busy)
        check($sformatf("vec%0d_cur_ch", i), 32'(cur_ch), 32'(vecs[i].e_ch));
    end

    // ---------------- full burst of BURST beats, ARB gap, re-grant ----------------
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    check("burst_hold_raised", 32'(hold), 32'd1);
    tick();
    drive(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    check("burst_first_grant", 32'(dack), 32'b0001);
    check("burst_first_ch", 32'(cur_ch), 32'd0);
    xfer_done = 1'b1;
    beats = 0;
    guard = 0;
    while (dack == 4'b0001 && guard < 40) begin
      beats++;
      guard++;
      tick();
    end
    check("burst_beats", 32'(beats), 32'(BURST_TB));
    check("burst_arb_dack", 32'(dack), 32'd0);
    check("burst_arb_busy", 32'(busy), 32'd0);
    check("burst_arb_hold", 32'(hold), 32'd1);
    tick();
    check("burst_regrant", 32'(dack), 32'b0001);

    // ---------------- grant order with all channels requesting ----------------
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
`ifdef DMA_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    ngr = 0;
    guard = 0;
    while (ngr < 5 && guard < 40) begin
      tick();
      guard++;
      if (busy) begin
        order[ngr] = cur_ch;
        ngr++;
      end
    end
    check("order_count", 32'(ngr), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < ngr) check($sformatf("order_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // ---------------- reset while a grant is active ----------------
    check("midgrant_busy_before", 32'(busy), 32'd1);
    drive(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    check("midgrant_rst_hold", 32'(hold), 32'd0);
    check("midgrant_rst_dack", 32'(dack), 32'd0);
    check("midgrant_rst_busy", 32'(busy), 32'd0);
    drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("after_rst_first_dack", 32'(dack), 32'b0001);
    check("after_rst_first_ch", 32'(cur_ch), 32'd0);

    // ---------------- hlda withdrawn mid-grant ----------------
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    hlda = 1'b1;
    tick();
    check("hlda_drop_grant", 32'(dack), 32'b0010);
    hlda = 1'b0;
    tick();
    check("hlda_drop_dack", 32'(dack), 32'd0);
    check("hlda_drop_hold", 32'(hold), 32'd1);
    tick();
    tick();
    check("hlda_drop_hold_kept", 32'(hold), 32'd1);
    check("hlda_drop_no_dack", 32'(dack), 32'd0);
    hlda = 1'b1;
    tick();
    check("hlda_back_dack", 32'(dack), 32'b0010);
    check("hlda_back_ch", 32'(cur_ch), 32'd1);

    // ---------------- randomized traffic against the reference model ----------------
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    model_step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    compare_model(0);
    rd = 4'b0000;
    for (int c = 1; c <= 3000; c++) begin
      rr = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) rd = 4'($urandom_range(0, 15));
      rh = ($urandom_range(0, 9) < 8) ? hold : ~hold;
      drive(rr, rd, rh, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      model_step(reset_n, dreq, hlda, xfer_done, eop);
      tick();
      compare_model(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
